vga_scanout: RTL and testbench

- Downstream stage of the capture path: the capture stage writes 8-bit samples into the dual-port frame buffer BRAM at address x + y*SRC_W.
- This block reads the other BRAM port and generates 640x480@60 VGA timing.
- It places the stored SRC_W x SRC_H image inside the visible raster at a fixed offset. Outside that window it outputs black.
- It runs entirely in the pixel clock domain. BRAM is the only crossing.

---
 rtl/vga_scanout.sv | 129 ++++++++++++
 tb/tb_vga_scanout.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scanout: free-running raster timing plus a windowed image fetched from the
// read port of the frame-buffer BRAM, delivered through a two-stage pipeline.
module vga_scanout #(
    parameter int SRC_W    = 576,
    parameter int SRC_H    = 28,
    parameter int ADDR_W   = 14,
    parameter int X_OFF    = 32,
    parameter int Y_OFF    = 226,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic              V_CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    input  logic [7:0]        BRAM_DOUT,
    output logic [7:0]        PIXEL,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_DE,
    output logic              FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_LO  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_HI  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_LO  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_HI  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] WIN_X0     = 10'(X_OFF);
    localparam logic [9:0] WIN_X1     = 10'(X_OFF + SRC_W);
    localparam logic [9:0] WIN_X_LAST = 10'(X_OFF + SRC_W - 1);
    localparam logic [9:0] WIN_Y0     = 10'(Y_OFF);
    localparam logic [9:0] WIN_Y1     = 10'(Y_OFF + SRC_H);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);

    logic [9:0]        h_reg, v_reg, h_next, v_next;
    logic [ADDR_W-1:0] line_base_reg;
    logic              en_frame_reg;

    // Stage-0 decode of the raw counter position.
    logic hs0, vs0, de0, win0, first0, frame_end;

    // Stage-1 delayed copies, aligned with BRAM_ADDR.
    logic hs1_reg, vs1_reg, de1_reg, win1_reg, first1_reg;

    always_comb begin
        h_next = (h_reg == H_LAST) ? 10'd0 : h_reg + 10'd1;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
        end
    end

    always_comb begin
        hs0       = !((h_reg >= H_SYNC_LO) && (h_reg < H_SYNC_HI));
        vs0       = !((v_reg >= V_SYNC_LO) && (v_reg < V_SYNC_HI));
        de0       = (h_reg < H_VIS) && (v_reg < V_VIS);
        win0      = (h_reg >= WIN_X0) && (h_reg < WIN_X1) &&
                    (v_reg >= WIN_Y0) && (v_reg < WIN_Y1);
        first0    = (h_reg == 10'd0) && (v_reg == 10'd0);
        frame_end = (h_reg == H_LAST) && (v_reg == V_LAST);
    end

    always_ff @(posedge V_CLK or posedge RESET) begin
        if (RESET) begin
            h_reg         <= '0;
            v_reg         <= '0;
            line_base_reg <= '0;
            en_frame_reg  <= 1'b0;
            BRAM_ADDR     <= '0;
            hs1_reg       <= 1'b1;
            vs1_reg       <= 1'b1;
            de1_reg       <= 1'b0;
            win1_reg      <= 1'b0;
            first1_reg    <= 1'b0;
            PIXEL         <= 8'd0;
            VGA_HS        <= 1'b1;
            VGA_VS        <= 1'b1;
            VGA_DE        <= 1'b0;
            FRAME_START   <= 1'b0;
        end else begin
            h_reg <= h_next;
            v_reg <= v_next;

            // Running pointer replaces x + y*SRC_W; address holds outside the window.
            if (win0) begin
                if (h_reg == WIN_X0) begin
                    BRAM_ADDR <= line_base_reg;
                end else begin
                    BRAM_ADDR <= BRAM_ADDR + 1'b1;
                end
                if (h_reg == WIN_X_LAST) begin
                    line_base_reg <= line_base_reg + LINE_STEP;
                end
            end
            // Enable is latched only at the frame boundary so a frame is never torn.
            if (frame_end) begin
                line_base_reg <= '0;
                en_frame_reg  <= ENABLE;
            end

            hs1_reg    <= hs0;
            vs1_reg    <= vs0;
            de1_reg    <= de0;
            win1_reg   <= win0;
            first1_reg <= first0;

            // BRAM_DOUT corresponds to the BRAM_ADDR issued one cycle earlier.
            PIXEL       <= (win1_reg && en_frame_reg) ? BRAM_DOUT : 8'd0;
            VGA_HS      <= hs1_reg;
            VGA_VS      <= vs1_reg;
            VGA_DE      <= de1_reg;
            FRAME_START <= first1_reg;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster so several whole frames fit in a short run;
// outputs are compared every cycle against an arithmetic model of the raster and image.
module tb_vga_scanout;

    localparam int HA = 40, HF = 4, HSY = 6, HB = 6, HT = HA + HF + HSY + HB;
    localparam int VA = 24, VF = 2, VSY = 2, VB = 3, VT = VA + VF + VSY + VB;
    localparam int FR = HT * VT;
    localparam int SW = 20, SH = 6, AW = 7, XO = 8, YO = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_dout;
    logic [7:0]    pixel;
    logic          hs, vs, de, fs;
    logic [7:0]    mem [0:127];

    assign bram_dout = mem[bram_addr];

    always #5 clk = ~clk;

    vga_scanout #(
        .SRC_W(SW), .SRC_H(SH), .ADDR_W(AW), .X_OFF(XO), .Y_OFF(YO),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .V_CLK(clk), .RESET(rst), .ENABLE(enable),
        .BRAM_ADDR(bram_addr), .BRAM_DOUT(bram_dout), .PIXEL(pixel),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de), .FRAME_START(fs)
    );

    typedef struct {
        int   cyc;
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic chk_addr;
        int   addr;
    } spot_t;

    localparam int NSPOT = 16;
    spot_t spots [NSPOT];

    int   checks = 0;
    int   failures = 0;
    int   j;
    int   last_addr;
    int   memsum;
    logic en_ref [0:15];
    int   acc_de, acc_hs, acc_vs, acc_px;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic in_win(input int h, input int v);
        return (h >= XO) && (h < XO + SW) && (v >= YO) && (v < YO + SH);
    endfunction

    function automatic logic en_sched(input int jj);
        int f;
        int line;
        f = jj / FR;
        line = (jj % FR) / HT;
        case (f)
            0, 1:    return 1'b1;
            2:       return line < 15;
            3:       return line >= 5;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_hs", tag), 32'(hs), 32'd1);
        check($sformatf("%s_vs", tag), 32'(vs), 32'd1);
        check($sformatf("%s_de", tag), 32'(de), 32'd0);
        check($sformatf("%s_fs", tag), 32'(fs), 32'd0);
        check($sformatf("%s_pixel", tag), 32'(pixel), 32'd0);
        check($sformatf("%s_addr", tag), 32'(bram_addr), 32'd0);
    endtask

    // Outputs sampled after posedge j show position j-2; BRAM_ADDR shows position j-1.
    task automatic check_cycle();
        int   p, q, h, v, f;
        logic ehs, evs, ede, efs;
        int   epx;
        p = j - 2;
        q = j - 1;
        ehs = 1'b1; evs = 1'b1; ede = 1'b0; efs = 1'b0; epx = 0;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            f = p / FR;
            ehs = !((h >= HA + HF) && (h < HA + HF + HSY));
            evs = !((v >= VA + VF) && (v < VA + VF + VSY));
            ede = (h < HA) && (v < VA);
            efs = (h == 0) && (v == 0);
            if (en_ref[f] && in_win(h, v)) epx = int'(mem[(h - XO) + (v - YO) * SW]);
        end
        if (q >= 0) begin
            h = q % HT;
            v = (q / HT) % VT;
            if (in_win(h, v)) last_addr = (h - XO) + (v - YO) * SW;
        end
        check($sformatf("hs@%0d", j), 32'(hs), 32'(ehs));
        check($sformatf("vs@%0d", j), 32'(vs), 32'(evs));
        check($sformatf("de@%0d", j), 32'(de), 32'(ede));
        check($sformatf("fs@%0d", j), 32'(fs), 32'(efs));
        check($sformatf("pixel@%0d", j), 32'(pixel), 32'(epx));
        check($sformatf("addr@%0d", j), 32'(bram_addr), 32'(last_addr));

        for (int k = 0; k < NSPOT; k++) begin
            if (spots[k].cyc == j) begin
                check($sformatf("spot%0d_hs", k), 32'(hs), 32'(spots[k].hs));
                check($sformatf("spot%0d_vs", k), 32'(vs), 32'(spots[k].vs));
                check($sformatf("spot%0d_de", k), 32'(de), 32'(spots[k].de));
                check($sformatf("spot%0d_fs", k), 32'(fs), 32'(spots[k].fs));
                if (spots[k].chk_addr)
                    check($sformatf("spot%0d_addr", k), 32'(bram_addr), 32'(spots[k].addr));
                $display("spot %0d cyc=%0d hs=%0d vs=%0d de=%0d fs=%0d addr=%0d",
                         k, j, hs, vs, de, fs, bram_addr);
            end
        end

        if (p >= 0) begin
            acc_de += int'(de);
            acc_hs += int'(!hs);
            acc_vs += int'(!vs);
            acc_px += int'(pixel);
            if (p % FR == FR - 1) begin
                f = p / FR;
                check($sformatf("frame%0d_de_count", f), 32'(acc_de), 32'(HA * VA));
                check($sformatf("frame%0d_hs_low", f), 32'(acc_hs), 32'(HSY * VT));
                check($sformatf("frame%0d_vs_low", f), 32'(acc_vs), 32'(VSY * HT));
                check($sformatf("frame%0d_pixel_sum", f), 32'(acc_px),
                      en_ref[f] ? 32'(memsum) : 32'd0);
                $display("frame %0d en=%0d de=%0d hs_low=%0d vs_low=%0d pixel_sum=%0d",
                         f, en_ref[f], acc_de, acc_hs, acc_vs, acc_px);
                acc_de = 0; acc_hs = 0; acc_vs = 0; acc_px = 0;
            end
        end
    endtask

    task automatic step(input logic en_next);
        @(posedge clk);
        j++;
        @(negedge clk);
        check_cycle();
        enable = en_next;
        if (j % FR == FR - 1) en_ref[j / FR + 1] = en_next;
    endtask

    task automatic model_restart();
        j = 0;
        last_addr = 0;
        for (int k = 0; k < 16; k++) en_ref[k] = 1'b0;
        acc_de = 0; acc_hs = 0; acc_vs = 0; acc_px = 0;
    endtask

    initial begin
        // Hand-derived raster landmarks for the reduced geometry, relative to reset release.
        spots[0]  = '{2,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        spots[1]  = '{3,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        spots[2]  = '{41,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        spots[3]  = '{42,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        spots[4]  = '{46,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        spots[5]  = '{51,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        spots[6]  = '{52,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        spots[7]  = '{513,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        spots[8]  = '{569,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 20};
        spots[9]  = '{812,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 119};
        spots[10] = '{900,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 119};
        spots[11] = '{1346, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        spots[12] = '{1458, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        spots[13] = '{1570, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        spots[14] = '{1738, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        spots[15] = '{1739, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        memsum = 0;
        for (int k = 0; k < 128; k++) begin
            mem[k] = 8'($urandom_range(1, 255));
            if (k < SW * SH) memsum += int'(mem[k]);
        end

        rst = 1'b1;
        enable = 1'b0;
        model_restart();
        repeat (5) begin
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        rst = 1'b0;
        enable = 1'b1;
        $display("reset released, running %0d frames", 7);

        // Frame 0 black (enable not yet latched), 1-2 image, 3 black, 4 image, 5-6 random.
        while (j < 7 * FR) step(en_sched(j));

        while (j % FR != 12 * HT + 19) step(1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        $display("async reset asserted mid-frame at h=20 v=12");
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("reset_pulse");
        end
        rst = 1'b0;
        model_restart();
        enable = 1'b1;
        while (j < 2 * FR + 2) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
